// File: rtl/disp_scan_ctrl_pkg.sv
// Shared types and defaults for the multiplexed 7-segment scan controller.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int         DEF_NDIG  = 4;
  localparam int         DEF_DIV   = 50000;
  localparam int         DEF_BLANK = 16;
  localparam logic [7:0] SEG_OFF   = 8'hFF;

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Host-side bundle for the scan controller: display data in, drive pins and debug state out.
interface disp_scan_ctrl_if
  import disp_pkg::*;
#(
  parameter int NDIG = DEF_NDIG
);
  // load is a one-cycle strobe with no back-pressure: value/dp/lz_en are taken
  // on every clock edge where load=1; the last strobe before a frame boundary wins.
  logic              enable;
  logic              load;
  logic [4*NDIG-1:0] value;
  logic [NDIG-1:0]   dp;
  logic              lz_en;
  logic [7:0]        seg;
  logic [NDIG-1:0]   an;
  logic              frame_done;
  state_t            dbg_state;
  logic              dbg_pend_valid;

  modport master (
    output enable, load, value, dp, lz_en,
    input  seg, an, frame_done, dbg_state, dbg_pend_valid
  );

  modport slave (
    input  enable, load, value, dp, lz_en,
    output seg, an, frame_done, dbg_state, dbg_pend_valid
  );
endinterface

// File: rtl/disp_scan_ctrl_to7seg.sv
// Hex nibble to active-low 7-segment pattern; seg[7] is the decimal point.
module to7seg (
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);
  logic [6:0] font;

  always_comb begin
    font = 7'h7F;
    case (nib)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      4'hF: font = 7'h0E;
      default: font = 7'h7F;
    endcase
  end

  assign seg = {~dp, font};
endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed digit scanner with double-buffered display data and leading-zero blanking.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NDIG  = DEF_NDIG,
  parameter int DIV   = DEF_DIV,
  parameter int BLANK = DEF_BLANK
) (
  input  logic           clk,
  input  logic           rst_n,
  disp_scan_ctrl_if.slave bus
);
  localparam int              CW        = $clog2(DIV);
  localparam int              IW        = $clog2(NDIG);
  localparam logic [CW-1:0]   SHOW_LAST = CW'(DIV - BLANK - 1);
  localparam logic [CW-1:0]   GAP_LAST  = CW'(BLANK - 1);
  localparam logic [IW-1:0]   IDX_LAST  = IW'(NDIG - 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic              frame_end, xfer;
  logic [4*NDIG-1:0] act_value, pend_value;
  logic [NDIG-1:0]   act_dp, pend_dp;
  logic              act_lz, pend_lz, pend_valid;
  logic [NDIG-1:0]   blank;
  logic [3:0]        cur_nib;
  logic [7:0]        dec_seg, seg_nxt, seg_r;
  logic [NDIG-1:0]   an_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Pending data moves to active only at IDLE->SHOW or at the end of the last GAP.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    frame_end = 1'b0;
    xfer      = 1'b0;
    if (!bus.enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          xfer      = 1'b1;
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_nxt = GAP;
            cnt_nxt   = '0;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state_nxt = SHOW;
            cnt_nxt   = '0;
            if (idx == IDX_LAST) begin
              idx_nxt   = '0;
              frame_end = 1'b1;
              xfer      = 1'b1;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // A load coinciding with a transfer bypasses the pending buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_value  <= '0;
      act_dp     <= '0;
      act_lz     <= 1'b0;
      pend_value <= '0;
      pend_dp    <= '0;
      pend_lz    <= 1'b0;
      pend_valid <= 1'b0;
    end else if (xfer) begin
      if (bus.load) begin
        act_value <= bus.value;
        act_dp    <= bus.dp;
        act_lz    <= bus.lz_en;
      end else if (pend_valid) begin
        act_value <= pend_value;
        act_dp    <= pend_dp;
        act_lz    <= pend_lz;
      end
      pend_valid <= 1'b0;
    end else if (bus.load) begin
      pend_value <= bus.value;
      pend_dp    <= bus.dp;
      pend_lz    <= bus.lz_en;
      pend_valid <= 1'b1;
    end
  end

  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_above = zero_above && (act_value[4*i +: 4] == 4'h0);
      blank[i]   = act_lz && zero_above && (i != 0);
    end
  end

  assign cur_nib = act_value[{idx, 2'b00} +: 4];

  to7seg u_dec (
    .nib (cur_nib),
    .dp  (act_dp[idx]),
    .seg (dec_seg)
  );

  assign seg_nxt = {dec_seg[7], blank[idx] ? 7'h7F : dec_seg[6:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= SEG_OFF;
      an_r  <= '1;
    end else if (state == SHOW) begin
      seg_r <= seg_nxt;
      an_r  <= ~(NDIG'(1) << idx);
    end else begin
      seg_r <= SEG_OFF;
      an_r  <= '1;
    end
  end

  assign bus.seg            = seg_r;
  assign bus.an             = an_r;
  assign bus.frame_done     = frame_end;
  assign bus.dbg_state      = state;
  assign bus.dbg_pend_valid = pend_valid;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with NDIG=4, DIV=8, BLANK=2.
module tb_disp_scan_ctrl;
  import disp_pkg::*;

  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int SHOWN = DIV - BLANK;
  localparam int FRAME = DIV * NDIG;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  disp_scan_ctrl_if #(.NDIG(NDIG)) bus ();

  disp_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dp;
    logic        lz;
    logic [31:0] exp_seg;  // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    bus.enable = 1'b0;
    bus.load   = 1'b0;
    bus.value  = '0;
    bus.dp     = '0;
    bus.lz_en  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // k counts negedges after the enabling edge; outputs at k reflect state cycle k-1.
  task automatic scan(input int k0, input int k1, input logic [31:0] segs);
    for (int k = k0; k <= k1; k++) begin
      int         s, d, p;
      logic [3:0] ea;
      logic [7:0] es;
      @(negedge clk);
      ea = 4'hF;
      es = 8'hFF;
      if (k > 0) begin
        s = k - 1;
        d = (s / DIV) % NDIG;
        p = s % DIV;
        if (p < SHOWN) begin
          ea = ~(4'b0001 << d);
          es = segs[8*d +: 8];
        end
      end
      check($sformatf("an k=%0d", k), {28'b0, bus.an}, {28'b0, ea});
      check($sformatf("seg k=%0d", k), {24'b0, bus.seg}, {24'b0, es});
      check($sformatf("frame_done k=%0d", k), {31'b0, bus.frame_done},
            {31'b0, (k % FRAME) == (FRAME - 1)});
    end
  endtask

  task automatic start_with(input logic [15:0] v);
    @(negedge clk);
    bus.value  = v;
    bus.dp     = 4'b0000;
    bus.lz_en  = 1'b0;
    bus.load   = 1'b1;
    bus.enable = 1'b1;
  endtask

  initial begin
    logic [31:0] s1234, sabcd, s5678;
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    s1234  = {8'hF9, 8'hA4, 8'hB0, 8'h99};
    sabcd  = {8'h88, 8'h83, 8'hC6, 8'hA1};
    s5678  = {8'h92, 8'h82, 8'hF8, 8'h80};

    vecs[0] = '{16'h1234, 4'b0000, 1'b0, s1234};
    vecs[1] = '{16'h0050, 4'b0100, 1'b1, {8'hFF, 8'h7F, 8'h92, 8'hC0}};
    vecs[2] = '{16'hABCD, 4'b1010, 1'b0, {8'h08, 8'h83, 8'h46, 8'hA1}};
    vecs[3] = '{16'h0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[4] = '{16'h0800, 4'b0001, 1'b1, {8'hFF, 8'h80, 8'hC0, 8'h40}};
    vecs[5] = '{16'h5678, 4'b0000, 1'b1, s5678};
    vecs[6] = '{16'h9EF0, 4'b0000, 1'b0, {8'h90, 8'h86, 8'h8E, 8'hC0}};

    // reset state
    do_reset();
    check("rst an", {28'b0, bus.an}, 32'h0000_000F);
    check("rst seg", {24'b0, bus.seg}, 32'h0000_00FF);
    check("rst frame_done", {31'b0, bus.frame_done}, 32'd0);
    check("rst state", {30'b0, bus.dbg_state}, {30'b0, IDLE});
    check("rst pend_valid", {31'b0, bus.dbg_pend_valid}, 32'd0);

    // table: two loads while idle (latest wins), then enable and scan one frame
    for (int v = 0; v < 7; v++) begin
      do_reset();
      @(negedge clk);
      bus.value = ~vecs[v].val;
      bus.dp    = ~vecs[v].dp;
      bus.lz_en = ~vecs[v].lz;
      bus.load  = 1'b1;
      @(negedge clk);
      bus.value = vecs[v].val;
      bus.dp    = vecs[v].dp;
      bus.lz_en = vecs[v].lz;
      @(negedge clk);
      bus.load = 1'b0;
      check($sformatf("vec%0d pend_valid", v), {31'b0, bus.dbg_pend_valid}, 32'd1);
      check($sformatf("vec%0d idle an", v), {28'b0, bus.an}, 32'h0000_000F);
      bus.enable = 1'b1;
      scan(0, FRAME, vecs[v].exp_seg);
      check($sformatf("vec%0d pend cleared", v), {31'b0, bus.dbg_pend_valid}, 32'd0);
      bus.enable = 1'b0;
    end

    // mid-frame load is deferred to the next frame; load on enable goes straight to active
    do_reset();
    start_with(16'h1234);
    scan(0, 0, s1234);
    bus.load = 1'b0;
    check("midload bypass pend", {31'b0, bus.dbg_pend_valid}, 32'd0);
    scan(1, 10, s1234);
    bus.value = 16'hABCD;
    bus.load  = 1'b1;
    scan(11, 11, s1234);
    bus.load = 1'b0;
    check("midload pend_valid", {31'b0, bus.dbg_pend_valid}, 32'd1);
    scan(12, FRAME, s1234);
    scan(FRAME + 1, 2 * FRAME, sabcd);
    check("midload pend after", {31'b0, bus.dbg_pend_valid}, 32'd0);
    bus.enable = 1'b0;

    // load on the frame_done cycle
    do_reset();
    start_with(16'h1234);
    scan(0, 0, s1234);
    bus.load = 1'b0;
    scan(1, FRAME - 1, s1234);
    bus.value = 16'h5678;
    bus.load  = 1'b1;
    scan(FRAME, FRAME, s1234);
    bus.load = 1'b0;
    check("fdload pend_valid", {31'b0, bus.dbg_pend_valid}, 32'd0);
    scan(FRAME + 1, 2 * FRAME, s5678);
    bus.enable = 1'b0;

    // enable dropped during digit 2 SHOW
    do_reset();
    start_with(16'h1234);
    scan(0, 0, s1234);
    bus.load = 1'b0;
    scan(1, 19, s1234);
    bus.enable = 1'b0;
    scan(20, 20, s1234);
    check("disable state", {30'b0, bus.dbg_state}, {30'b0, IDLE});
    @(negedge clk);
    check("disable an", {28'b0, bus.an}, 32'h0000_000F);
    check("disable seg", {24'b0, bus.seg}, 32'h0000_00FF);
    check("disable frame_done", {31'b0, bus.frame_done}, 32'd0);
    bus.enable = 1'b1;
    scan(0, FRAME, s1234);

    // asynchronous reset mid-SHOW, then restart on cleared active data
    do_reset();
    start_with(16'hABCD);
    scan(0, 0, sabcd);
    bus.load = 1'b0;
    scan(1, 3, sabcd);
    #2;
    rst_n = 1'b0;
    #1;
    check("async an", {28'b0, bus.an}, 32'h0000_000F);
    check("async seg", {24'b0, bus.seg}, 32'h0000_00FF);
    check("async state", {30'b0, bus.dbg_state}, {30'b0, IDLE});
    check("async frame_done", {31'b0, bus.frame_done}, 32'd0);
    #1;
    rst_n = 1'b1;
    scan(0, FRAME, {8'hC0, 8'hC0, 8'hC0, 8'hC0});
    bus.enable = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
